pwm_compare: RTL and testbench

PWM_COMPARE -- requirements
Module: pwm_compare

---
 rtl/pwm_compare.sv | 92 +++++++++
 tb/tb_pwm_compare.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_compare.sv
// pwm_compare: double-buffered compare PWM driving a complementary output pair.
// Define PWM_COMPARE_DEADTIME_EN to insert dead time between out_p and out_n.
module pwm_compare #(
  parameter int BITS = 8,
  parameter int DT_BITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [BITS-1:0]    cnt_in,
  input  logic               ovf_in,
  input  logic [BITS-1:0]    cmp_value,
  input  logic               cmp_load,
  input  logic [DT_BITS-1:0] dead_time,
  output logic               out_p,
  output logic               out_n,
  output logic               cmp_match
);
  logic [BITS-1:0] shadow, active;
  logic pending, raw_q;
  // A load coinciding with period end bypasses the shadow and takes effect at once
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shadow <= '0;
      active <= '0;
      pending <= 1'b0;
      raw_q <= 1'b0;
      cmp_match <= 1'b0;
    end else begin
      raw_q <= cnt_in < active;
      cmp_match <= ena & (cnt_in == active);
      if (cmp_load) shadow <= cmp_value;
      if (cmp_load & ovf_in) active <= cmp_value;
      else if (ovf_in & pending) active <= shadow;
      pending <= cmp_load ? ~ovf_in : pending & ~ovf_in;
    end
`ifdef PWM_COMPARE_DEADTIME_EN
  typedef enum logic [2:0] {OFF, P_ON, N_ON, DT_P, DT_N} state_t;
  state_t state, state_n;
  logic [DT_BITS-1:0] dtc, dtc_n;
  logic dt_zero;
  assign dt_zero = dead_time == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= OFF;
      dtc <= '0;
      out_p <= 1'b0;
      out_n <= 1'b0;
    end else begin
      state <= state_n;
      dtc <= dtc_n;
      out_p <= state_n == P_ON;
      out_n <= state_n == N_ON;
    end
  // OFF behaves like N_ON so a zero dead time never parks the FSM in DT_P
  always_comb begin
    state_n = state;
    dtc_n = dtc;
    if (!ena) state_n = OFF;
    else case (state)
      OFF, N_ON: if (raw_q) begin
        state_n = dt_zero ? P_ON : DT_P;
        dtc_n = dead_time;
      end else state_n = N_ON;
      P_ON: if (!raw_q) begin
        state_n = dt_zero ? N_ON : DT_N;
        dtc_n = dead_time;
      end
      DT_P: begin
        dtc_n = dtc - 1'b1;
        state_n = !raw_q ? N_ON : dtc == DT_BITS'(1) ? P_ON : DT_P;
      end
      DT_N: begin
        dtc_n = dtc - 1'b1;
        state_n = raw_q ? P_ON : dtc == DT_BITS'(1) ? N_ON : DT_N;
      end
      default: state_n = OFF;
    endcase
  end
`else
  logic dt_unused;
  assign dt_unused = ^dead_time;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_p <= 1'b0;
      out_n <= 1'b0;
    end else begin
      out_p <= ena & raw_q;
      out_n <= ena & ~raw_q;
    end
`endif
endmodule

// File: tb/tb_pwm_compare.sv
// tb_pwm_compare: randomized and directed checks of pwm_compare against a cycle model.
module tb_pwm_compare;
  localparam int BITS = 4;
  localparam int DT_BITS = 4;
  logic clk = 1'b0, rst = 1'b1, ena = 1'b0, ovf_in = 1'b0, cmp_load = 1'b0;
  logic [BITS-1:0] cnt_in = '0, cmp_value = '0;
  logic [DT_BITS-1:0] dead_time = '0;
  logic out_p, out_n, cmp_match;
  int n_checks = 0, n_fail = 0;
  int sum_p, sum_n, sum_lo;
  int m_act, m_shadow;
  bit m_pend, m_raw, m_p, m_n, m_match;
`ifdef PWM_COMPARE_DEADTIME_EN
  localparam bit DT = 1'b1;
  bit m_off, m_lvl;
  int m_run, m_dlat;
`else
  localparam bit DT = 1'b0;
`endif

  pwm_compare #(.BITS(BITS), .DT_BITS(DT_BITS)) dut (
    .clk(clk), .rst(rst), .ena(ena), .cnt_in(cnt_in), .ovf_in(ovf_in),
    .cmp_value(cmp_value), .cmp_load(cmp_load), .dead_time(dead_time),
    .out_p(out_p), .out_n(out_n), .cmp_match(cmp_match)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_shadow = 0; m_pend = 0; m_raw = 0;
    m_p = 0; m_n = 0; m_match = 0;
`ifdef PWM_COMPARE_DEADTIME_EN
    m_off = 1; m_lvl = 0; m_run = 0; m_dlat = 0;
`endif
  endtask

  // Output level follows the raw compare; with dead time, a change of level is
  // only committed once the new raw level has persisted for dead_time+1 samples.
  task automatic step();
    bit rq;
    @(posedge clk);
    rq = m_raw;
    m_match = ena && (cnt_in == m_act);
    m_raw = cnt_in < m_act;
`ifdef PWM_COMPARE_DEADTIME_EN
    if (!ena) begin
      m_off = 1; m_p = 0; m_n = 0;
    end else begin
      if (m_off) begin m_off = 0; m_lvl = 0; m_run = 0; end
      if (rq == m_lvl) m_run = 0;
      else begin
        if (m_run == 0) m_dlat = dead_time;
        m_run++;
        if (m_run > m_dlat) begin m_lvl = rq; m_run = 0; end
      end
      m_p = m_run == 0 && m_lvl;
      m_n = m_run == 0 && !m_lvl;
    end
`else
    m_p = ena && rq;
    m_n = ena && !rq;
`endif
    if (cmp_load) m_shadow = cmp_value;
    if (cmp_load && ovf_in) begin m_act = cmp_value; m_pend = 0; end
    else if (cmp_load) m_pend = 1;
    else if (ovf_in && m_pend) begin m_act = m_shadow; m_pend = 0; end
    #1;
    chk("out_p", out_p, m_p);
    chk("out_n", out_n, m_n);
    chk("cmp_match", cmp_match, m_match);
    chk("no_overlap", out_p & out_n, 0);
    sum_p += int'(out_p);
    sum_n += int'(out_n);
    sum_lo += int'(!out_p && !out_n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_p", out_p, 0);
    chk("rst_out_n", out_n, 0);
    chk("rst_match", cmp_match, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic period(input int load_at, input int val);
    for (int c = 0; c < 10; c++) begin
      cnt_in = BITS'(c);
      ovf_in = c == 9;
      cmp_load = c == load_at;
      cmp_value = BITS'(val);
      step();
    end
    cmp_load = 1'b0;
    ovf_in = 1'b0;
  endtask

  task automatic window();
    sum_p = 0; sum_n = 0; sum_lo = 0;
    period(-1, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_out_p", out_p, 0);
    chk("init_out_n", out_n, 0);
    chk("init_match", cmp_match, 0);
    rst = 1'b0;
    ena = 1'b1;
    period(0, 4);
    period(-1, 0);
    window();
    chk("duty4_p", sum_p, 4);
    chk("duty4_n", sum_n, 6);
    dead_time = 2;
    period(-1, 0);
    window();
    chk("dt2_low", sum_lo, DT ? 4 : 0);
    chk("dt2_p", sum_p, DT ? 2 : 4);
    dead_time = 0;
    period(5, 7);
    window();
    chk("duty7_p", sum_p, 7);
    period(9, 3);
    window();
    chk("duty3_p", sum_p, 3);
    period(9, 0);
    window();
    chk("duty0_p", sum_p, 0);
    period(9, 15);
    period(-1, 0);
    window();
    chk("duty100_n", sum_n, 0);
    dead_time = 3;
    cnt_in = 9; ovf_in = 1'b1; cmp_load = 1'b1; cmp_value = 5;
    step();
    ovf_in = 1'b0; cmp_load = 1'b0;
    repeat (4) step();
    sum_p = 0;
    cnt_in = 0;
    step();
    cnt_in = 9;
    repeat (6) step();
    chk("glitch_p", sum_p, DT ? 0 : 1);
    chk("glitch_n_end", out_n, 1);
    cnt_in = 0;
    repeat (2) step();
    do_reset();
    cnt_in = 9;
    repeat (3) step();
    period(9, 4);
    period(-1, 0);
    for (int i = 0; i < 30; i++) begin
      cnt_in = BITS'(i % 10);
      ovf_in = (i % 10) == 9;
      ena = !(i >= 12 && i < 17);
      step();
      if (i >= 13 && i < 17) chk("ena_off_outs", {out_p, out_n, cmp_match}, 0);
    end
    ovf_in = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      cnt_in = BITS'($urandom);
      ovf_in = $urandom_range(0, 7) == 0;
      cmp_load = $urandom_range(0, 5) == 0;
      cmp_value = BITS'($urandom);
      if ($urandom_range(0, 9) == 0) dead_time = DT_BITS'($urandom_range(0, 7));
      ena = $urandom_range(0, 19) != 0;
      if ($urandom_range(0, 499) == 0) do_reset();
      else step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
